// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of one fixed-latency memory port
// between the instruction-fetch and data requesters.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);
    state_t            state_q, state_d;
    logic              owner_q, owner_d, last_q, last_d, we_q, we_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic              grant, pick, last_cycle, capture;
    assign grant      = state_q == IDLE && (if_req || d_req);
    // pick = 1 selects data; on a tie the loser of the previous grant wins
    assign pick       = (if_req && d_req) ? !last_q : d_req;
    assign last_cycle = state_q == ACCESS && cnt_q == 4'd0;
    assign capture    = last_cycle && !we_q;
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end
    always_comb begin
        state_d = state_q == IDLE   ? (grant ? ACCESS : IDLE) :
                  state_q == ACCESS ? (last_cycle ? DONE : ACCESS) : IDLE;
    end
    always_comb begin
        owner_d    = grant ? pick : owner_q;
        last_d     = grant ? pick : last_q;
        we_d       = grant ? pick && d_we : we_q;
        addr_d     = grant ? (pick ? d_addr : if_addr) : addr_q;
        wdata_d    = grant && pick ? d_wdata : wdata_q;
        cnt_d      = grant ? LAT_M1 : (state_q == ACCESS && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
        if_rdata_d = capture && !owner_q ? mem_rdata : if_rdata_q;
        d_rdata_d  = capture && owner_q ? mem_rdata : d_rdata_q;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            owner_q    <= owner_d;
            last_q     <= last_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end
    always_comb begin
        busy   = state_q != IDLE;
        mem_en = state_q == ACCESS;
        mem_we = state_q == ACCESS && we_q;
        if_ack = state_q == DONE && !owner_q;
        d_ack  = state_q == DONE && owner_q;
    end
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign owner     = owner_q;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the instruction-fetch requester and the data (load/store) requester of the multicycle core.
- Round-robin arbitration, latches the winner's command, and sequences a fixed-latency memory access.
- Returns read data and a one-cycle acknowledge to the winner.
- Sits between the multicycle control/datapath and the memory model.

Parameters:
ADDR_W, 32, address width of requesters and memory
DATA_W, 32, data width
MEM_LAT, 2, memory access cycles per transfer (legal range 1..15)

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-low
if_req  input  1  fetch request; held high until if_ack
if_addr  input  ADDR_W  fetch address
if_ack  output  1  one-cycle fetch completion pulse
if_rdata  output  DATA_W  fetched instruction
d_req  input  1  data request; held high until d_ack
d_we  input  1  1 = store, 0 = load
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  store data
d_ack  output  1  one-cycle data completion pulse
d_rdata  output  DATA_W  load data
mem_en  output  1  memory access enable
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data
busy  output  1  high when state is not IDLE
owner  output  1  current/last grant: 0 = fetch, 1 = data

Behaviour:
- Interface timing: one clock, clk. Reset rst is synchronous and active-low.
- Reset (rst low at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0, including if_rdata, d_rdata, mem_* and owner.
  - Internal last_grant goes to data, so the first tie goes to fetch.
  - Latency counter clears.
- State machine: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requests: grant the requester that is not last_grant.
  - On grant, latch addr, we (forced 0 for fetch) and wdata into command registers; update owner and last_grant; load counter with MEM_LAT-1; go to ACCESS.
- ACCESS:
  - mem_en=1 and mem_addr/mem_wdata are driven from the command registers.
  - mem_we=1 only for a data store.
  - Counter decrements each cycle. When it is 0, the cycle is the last access cycle: go to DONE.
  - On a read, mem_rdata is captured at the end of the last access cycle into if_rdata or d_rdata (owner's port only).
- DONE:
  - mem_en=0, mem_we=0.
  - Assert exactly one ack, the owner's, for one cycle.
  - Go to IDLE.
- Latency: req first seen high in IDLE at cycle T -> ack high in cycle T+MEM_LAT+1. Minimum spacing between grants is MEM_LAT+2 cycles.
- Requester rules:
  - A requester must hold req and its command stable until ack.
  - It deasserts req or presents a new command on the edge ending the ack cycle.
  - Command inputs are ignored outside the IDLE grant cycle. Changing them mid-access does not affect mem_addr or mem_wdata.
- Fairness:
  - If both requesters remain high continuously, grants strictly alternate.
  - A lone requester may win repeatedly.
- Read data hold: if_rdata and d_rdata keep their value until the next completed read by the same port. Stores do not alter d_rdata.
- Outputs mem_addr and mem_wdata hold their last values in IDLE/DONE. Only mem_en and mem_we qualify them.
- Reset mid-operation (ACCESS or DONE):
  - Access is aborted; no ack is issued.
  - mem_en and mem_we are 0 from the next cycle.
  - Pending requests are re-arbitrated after rst returns high, fetch first.
- Counter width: 4 bits. MEM_LAT=1 gives a single ACCESS cycle.

Test Plan:
- Single fetch, MEM_LAT=2: after reset, if_req=1, if_addr=0x100, memory returns 0x00500093 -> mem_en high 2 cycles with mem_addr=0x100 and mem_we=0; if_ack pulses in cycle T+3; if_rdata=0x00500093; d_ack stays 0.
- Data store: d_req=1, d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF -> mem_we=1 for 2 cycles with that addr/data; d_ack pulses once; d_rdata stays unchanged (0).
- Simultaneous requests after reset, both held: fetch 0x104 and data load 0x204 -> fetch granted first (owner=0), data granted next (owner=1); acks 4 cycles apart; continuous requests keep alternating F,D,F,D.
- Command changes mid-access: d_addr changed from 0x300 to 0x3FC during ACCESS -> mem_addr stays 0x300 throughout.
- Reset mid-access: rst low in the second ACCESS cycle of a fetch -> next cycle mem_en=0, no if_ack, outputs 0; after release with if_req still high, a fresh fetch completes normally.
- MEM_LAT=1 build: lone data load 0x10 -> ack 2 cycles after req; back-to-back loads granted every 3 cycles.
